// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N requesters.
// Each write takes IDLE -> GRANT -> DONE; a synchronous clear takes priority and is deferred if a write is in flight.
module rr_shared_reg_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk_i,
  input  logic                 clr_i,
  input  logic [N-1:0]         req_i,
  input  logic [N*WIDTH-1:0]   din_i,
  input  logic                 sclr_i,
  output logic [N-1:0]         gnt_o,
  output logic [N-1:0]         ack_o,
  output logic [WIDTH-1:0]     q_o,
  output logic [IW-1:0]        owner_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic               clr_pend_q, clr_pend_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [N-1:0]       ack_q, ack_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               busy_q;

  logic               found;
  logic [IW-1:0]      pick;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req_i[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    clr_pend_d = clr_pend_q;
    gnt_d      = gnt_q;
    ack_d      = ack_q;
    q_d        = q_q;
    owner_d    = owner_q;
    case (state_q)
      IDLE: begin
        if (sclr_i || clr_pend_q) begin
          state_d = CLEAR;
        end else if (found) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          win_d       = pick;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        q_d          = din_i[int'(win_q)*WIDTH +: WIDTH];
        owner_d      = win_q;
        ack_d        = '0;
        ack_d[win_q] = 1'b1;
        gnt_d        = '0;
        ptr_d        = win_q;
        if (sclr_i) clr_pend_d = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        ack_d   = '0;
        if (sclr_i) clr_pend_d = 1'b1;
        state_d = IDLE;
      end
      CLEAR: begin
        q_d        = '0;
        clr_pend_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        gnt_d   = '0;
        ack_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(N-1);
      win_q      <= '0;
      clr_pend_q <= 1'b0;
      gnt_q      <= '0;
      ack_q      <= '0;
      q_q        <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      clr_pend_q <= clr_pend_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      q_q        <= q_d;
      owner_q    <= owner_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign gnt_o   = gnt_q;
  assign ack_o   = ack_q;
  assign q_o     = q_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// Self-checking bench for rr_shared_reg_arbiter: vector table, directed corner cases, random vs reference model.
module tb_rr_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  req;
  logic [31:0] din;
  logic        sclr;
  logic [3:0]  gnt, ack;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  rr_shared_reg_arbiter #(.N(4), .WIDTH(8)) dut (
    .clk_i(clk), .clr_i(clr), .req_i(req), .din_i(din), .sclr_i(sclr),
    .gnt_o(gnt), .ack_o(ack), .q_o(q), .owner_o(owner), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 granted, 2 acknowledging, 3 clearing.
  int         m_phase, m_ptr, m_win, m_owner;
  bit         m_pend, m_busy;
  logic [7:0] m_q;
  logic [3:0] m_gnt, m_ack;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 3; m_win = 0; m_owner = 0; m_pend = 0; m_busy = 0;
    m_q = 8'h00; m_gnt = 4'h0; m_ack = 4'h0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic s, input logic [31:0] d);
    case (m_phase)
      0: if (s || m_pend) m_phase = 3;
         else if (r != 4'h0) begin
           m_win = rr_pick(r, m_ptr); m_gnt = 4'(1 << m_win); m_phase = 1;
         end
      1: begin
           m_q = d[m_win*8 +: 8]; m_owner = m_win; m_ack = 4'(1 << m_win);
           m_gnt = 4'h0; m_ptr = m_win; m_pend = m_pend | s; m_phase = 2;
         end
      2: begin m_ack = 4'h0; m_pend = m_pend | s; m_phase = 0; end
      default: begin m_q = 8'h00; m_pend = 0; m_phase = 0; end
    endcase
    m_busy = (m_phase != 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic s, input logic [31:0] d);
    req = r; sclr = s; din = d;
    @(posedge clk);
    #1;
    model_step(r, s, d);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_gnt"},   32'(gnt),   32'(m_gnt));
    check({tag, "_ack"},   32'(ack),   32'(m_ack));
    check({tag, "_q"},     32'(q),     32'(m_q));
    check({tag, "_owner"}, 32'(owner), 32'(m_owner));
    check({tag, "_busy"},  32'(busy),  32'(m_busy));
  endtask

  typedef struct {
    logic [3:0]  req;
    logic        sclr;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        busy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int acks, last_cyc, cyc, idx;
    logic [3:0] rq;

    // Single write of req2, then Q=3C via req0, then SCLR beating a pending request.
    tbl[0]  = '{4'b0100, 1'b0, 32'h00A5_0000, 4'b0100, 4'b0000, 8'h00, 2'd0, 1'b1};
    tbl[1]  = '{4'b0100, 1'b0, 32'h00A5_0000, 4'b0000, 4'b0100, 8'hA5, 2'd2, 1'b1};
    tbl[2]  = '{4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b0};
    tbl[3]  = '{4'b0001, 1'b0, 32'h0000_003C, 4'b0001, 4'b0000, 8'hA5, 2'd2, 1'b1};
    tbl[4]  = '{4'b0001, 1'b0, 32'h0000_003C, 4'b0000, 4'b0001, 8'h3C, 2'd0, 1'b1};
    tbl[5]  = '{4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'h3C, 2'd0, 1'b0};
    tbl[6]  = '{4'b0001, 1'b1, 32'h0000_0011, 4'b0000, 4'b0000, 8'h3C, 2'd0, 1'b1};
    tbl[7]  = '{4'b0001, 1'b0, 32'h0000_0011, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0};
    tbl[8]  = '{4'b0001, 1'b0, 32'h0000_0011, 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b1};
    tbl[9]  = '{4'b0001, 1'b0, 32'h0000_0011, 4'b0000, 4'b0001, 8'h11, 2'd0, 1'b1};
    tbl[10] = '{4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'h11, 2'd0, 1'b0};

    clr = 1'b1; req = 4'h0; sclr = 1'b0; din = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", 32'(q), 32'h0);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_owner", 32'(owner), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].req, tbl[i].sclr, tbl[i].din);
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("vec%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
      check($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].q));
      check($sformatf("vec%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    end

    // SCLR during a write to req1 is held off until the write completes.
    cycle(4'b0010, 1'b0, 32'h0000_7E00);
    check("pend_grant", 32'(gnt), 32'b0010);
    cycle(4'b0010, 1'b1, 32'h0000_7E00);
    check("pend_q_written", 32'(q), 32'h7E);
    check("pend_ack", 32'(ack), 32'b0010);
    cycle(4'b0000, 1'b0, 32'h0);
    check("pend_idle_busy", 32'(busy), 32'h0);
    cycle(4'b0010, 1'b0, 32'h0000_7E00);
    check("pend_clear_nogrant", 32'(gnt), 32'h0);
    check("pend_clear_busy", 32'(busy), 32'h1);
    cycle(4'b0010, 1'b0, 32'h0000_7E00);
    check("pend_q_cleared", 32'(q), 32'h0);
    check("pend_still_nogrant", 32'(gnt), 32'h0);
    cycle(4'b0010, 1'b0, 32'h0000_7E00);
    check("pend_then_grant", 32'(gnt), 32'b0010);
    cycle(4'b0010, 1'b0, 32'h0000_7E00);
    cycle(4'b0000, 1'b0, 32'h0);

    for (int i = 0; i < 20; i++) begin
      cycle(4'b0000, 1'b0, 32'hFFFF_FFFF);
      check("hold_gnt", 32'(gnt), 32'h0);
      check("hold_ack", 32'(ack), 32'h0);
      check("hold_busy", 32'(busy), 32'h0);
      check("hold_q", 32'(q), 32'h7E);
    end

    // Async reset while GNT is up; ptr was left at 1, so req0 winning proves ptr reset.
    cycle(4'b0100, 1'b0, 32'h0);
    #3;
    clr = 1'b1;
    #1;
    check("arst_q", 32'(q), 32'h0);
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_ack", 32'(ack), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    cycle(4'b1111, 1'b0, 32'h4433_2211);
    check("arst_first_grant", 32'(gnt), 32'b0001);
    cycle(4'b0000, 1'b0, 32'h4433_2211);
    cycle(4'b0000, 1'b0, 32'h0);

    clr = 1'b1;
    @(negedge clk);
    model_reset();
    clr = 1'b0;
    acks = 0; last_cyc = 0; cyc = 0; rq = 4'hF;
    while (acks < 5 && cyc < 40) begin
      cycle(rq, 1'b0, $urandom);
      cyc++;
      rq = 4'hF & ~ack;
      if (ack != 4'h0) begin
        idx = 0;
        for (int b = 0; b < 4; b++) if (ack[b]) idx = b;
        check("rr_order", 32'(idx), 32'(acks % 4));
        if (acks > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        acks++;
      end
    end
    check("rr_ack_count", 32'(acks), 32'd5);
    cycle(4'b0000, 1'b0, 32'h0);
    cycle(4'b0000, 1'b0, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0), $urandom);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
